// File: rtl/zbus_io_sequencer_if.sv
// ZX-bus I/O sequencer bus bundle: raw Z80 strobes and slot claims in,
// daisy-chain IORQs, free-bus drive, owner and internal strobes out.
interface zbus_io_sequencer_if;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic       m1_n;
    logic       porthit;
    logic       iorqge1;
    logic       iorqge2;
    logic       iorq1_n;
    logic       iorq2_n;
    logic       drive_ff;
    logic [1:0] owner;
    logic       io_rd_stb;
    logic       io_wr_stb;
    logic       inta_stb;
    logic       busy;

    // Sequencer side
    modport slave (
        input  iorq_n, rd_n, wr_n, m1_n, porthit, iorqge1, iorqge2,
        output iorq1_n, iorq2_n, drive_ff, owner, io_rd_stb, io_wr_stb,
               inta_stb, busy
    );

    // Z80 pins / slot logic side
    modport master (
        output iorq_n, rd_n, wr_n, m1_n, porthit, iorqge1, iorqge2,
        input  iorq1_n, iorq2_n, drive_ff, owner, io_rd_stb, io_wr_stb,
               inta_stb, busy
    );
endinterface

// File: rtl/zbus_io_sequencer.sv
// ZX-bus I/O cycle sequencer: synchronises the Z80 strobes into fclk,
// waits a settle window for IORQGE, then hands the cycle to the internal
// decoder, slot 1, slot 2 or the free bus (0xFF) and drives the chain.
module zbus_io_sequencer #(
    parameter int SETTLE = 3,
    parameter int CNT_W  = 2
) (
    input  logic                fclk,
    input  logic                rst_n,
    zbus_io_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_ARB, ST_ACTIVE, ST_INTA, ST_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               armed;
    logic [1:0]         sync_fill;

    logic m_iorq_n, m_rd_n, m_wr_n, m_m1_n;
    logic s_iorq_n, s_rd_n, s_wr_n, s_m1_n;
    logic r_porthit, r_iorqge1, r_iorqge2;

    // Two-flop synchronisers for the asynchronous Z80 strobes (idle high)
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            m_iorq_n  <= 1'b1;
            m_rd_n    <= 1'b1;
            m_wr_n    <= 1'b1;
            m_m1_n    <= 1'b1;
            s_iorq_n  <= 1'b1;
            s_rd_n    <= 1'b1;
            s_wr_n    <= 1'b1;
            s_m1_n    <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            m_iorq_n  <= bus.iorq_n;
            m_rd_n    <= bus.rd_n;
            m_wr_n    <= bus.wr_n;
            m_m1_n    <= bus.m1_n;
            s_iorq_n  <= m_iorq_n;
            s_rd_n    <= m_rd_n;
            s_wr_n    <= m_wr_n;
            s_m1_n    <= m_m1_n;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Single register stage on the claim lines from decoder and slots
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            r_porthit <= 1'b0;
            r_iorqge1 <= 1'b0;
            r_iorqge2 <= 1'b0;
        end else begin
            r_porthit <= bus.porthit;
            r_iorqge1 <= bus.iorqge1;
            r_iorqge2 <= bus.iorqge2;
        end
    end

    // Cycle FSM with registered chain, drive, owner and strobe outputs
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            armed         <= 1'b0;
            bus.iorq1_n   <= 1'b1;
            bus.iorq2_n   <= 1'b1;
            bus.drive_ff  <= 1'b0;
            bus.owner     <= 2'd0;
            bus.io_rd_stb <= 1'b0;
            bus.io_wr_stb <= 1'b0;
            bus.inta_stb  <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.io_rd_stb <= 1'b0;
            bus.io_wr_stb <= 1'b0;
            bus.inta_stb  <= 1'b0;
            // The synchroniser reset value (1) is not a real observation of
            // IORQ high, so arming waits until the pipeline holds pin data.
            if (s_iorq_n && sync_fill[1]) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (armed && !s_iorq_n) begin
                        bus.busy <= 1'b1;
                        if (s_m1_n) begin
                            state <= ST_SETTLE;
                            cnt   <= CNT_W'(SETTLE - 1);
                        end else begin
                            state        <= ST_INTA;
                            bus.drive_ff <= 1'b1;
                            bus.iorq1_n  <= 1'b1;
                            bus.iorq2_n  <= 1'b1;
                            bus.inta_stb <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (s_iorq_n) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= ST_ARB;
                        if (r_porthit) begin
                            bus.owner <= 2'd0;
                            if (!s_rd_n) begin
                                bus.io_rd_stb <= 1'b1;
                            end else if (!s_wr_n) begin
                                bus.io_wr_stb <= 1'b1;
                            end
                        end else if (r_iorqge1) begin
                            bus.owner <= 2'd1;
                        end else if (r_iorqge2) begin
                            bus.owner <= 2'd2;
                        end else begin
                            bus.owner <= 2'd3;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ARB: begin
                    state        <= ST_ACTIVE;
                    bus.iorq1_n  <= (bus.owner == 2'd0);
                    bus.iorq2_n  <= (bus.owner <= 2'd1);
                    bus.drive_ff <= (bus.owner == 2'd3) && !s_rd_n;
                end
                ST_ACTIVE: begin
                    if (s_iorq_n) begin
                        state        <= ST_DONE;
                        bus.iorq1_n  <= 1'b1;
                        bus.iorq2_n  <= 1'b1;
                        bus.drive_ff <= 1'b0;
                        bus.owner    <= 2'd0;
                    end else begin
                        bus.drive_ff <= (bus.owner == 2'd3) && !s_rd_n;
                    end
                end
                ST_INTA: begin
                    if (s_iorq_n) begin
                        state        <= ST_DONE;
                        bus.iorq1_n  <= 1'b1;
                        bus.iorq2_n  <= 1'b1;
                        bus.drive_ff <= 1'b0;
                        bus.owner    <= 2'd0;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zbus_io_sequencer.sv
// Bench for zbus_io_sequencer: directed and randomized I/O cycles, INTA,
// short aborted pulses and mid-cycle reset, against a claim-priority model.
module tb_zbus_io_sequencer;

    localparam int SETTLE = 3;
    localparam int SYNC   = 2;
    // Ticks from driving raw IORQ low to the ARB entry (strobe) and ACTIVE
    localparam int STB_AT = SYNC + SETTLE + 1;
    localparam int ACT_AT = STB_AT + 1;

    logic fclk  = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int tnow     = 0;
    int rd_seen  = 0;
    int wr_seen  = 0;
    int ia_seen  = 0;
    int stb_tick = 0;

    zbus_io_sequencer_if bus();

    zbus_io_sequencer #(.SETTLE(SETTLE), .CNT_W(2)) dut (
        .fclk  (fclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 fclk = ~fclk;

    task automatic chk(input string nm, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", nm, what, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
        tnow++;
        if (bus.io_rd_stb === 1'b1) begin rd_seen++; stb_tick = tnow; end
        if (bus.io_wr_stb === 1'b1) begin wr_seen++; stb_tick = tnow; end
        if (bus.inta_stb  === 1'b1) ia_seen++;
    endtask

    task automatic clear_counts();
        rd_seen  = 0;
        wr_seen  = 0;
        ia_seen  = 0;
        stb_tick = -1;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk(nm, "iorq1_n",  32'(bus.iorq1_n),  32'd1);
        chk(nm, "iorq2_n",  32'(bus.iorq2_n),  32'd1);
        chk(nm, "drive_ff", 32'(bus.drive_ff), 32'd0);
        chk(nm, "owner",    32'(bus.owner),    32'd0);
        chk(nm, "busy",     32'(bus.busy),     32'd0);
    endtask

    // Full I/O cycle; model: decoder beats slot 1 beats slot 2 beats free bus
    task automatic run_io(input logic p, input logic g1, input logic g2,
                          input logic rdl, input logic wrl, input int hold,
                          input string nm);
        logic [1:0] eo;
        logic       ei1, ei2, edf;
        int         erd, ewr, t0;
        eo  = p ? 2'd0 : (g1 ? 2'd1 : (g2 ? 2'd2 : 2'd3));
        ei1 = p;                  // slot 1 sees IORQ unless the decoder took it
        ei2 = p | g1;             // slot 2 sees it only if nobody upstream did
        edf = !(p | g1 | g2) && rdl;
        erd = (p && rdl) ? 1 : 0;
        ewr = (p && !rdl && wrl) ? 1 : 0;

        bus.porthit = p;
        bus.iorqge1 = g1;
        bus.iorqge2 = g2;
        bus.rd_n    = !rdl;
        bus.wr_n    = !wrl;
        bus.m1_n    = 1'b1;
        tick();
        clear_counts();
        t0 = tnow;
        bus.iorq_n = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (k == ACT_AT) begin
                chk(nm, "owner",    32'(bus.owner),    32'(eo));
                chk(nm, "iorq1_n",  32'(bus.iorq1_n),  32'(ei1));
                chk(nm, "iorq2_n",  32'(bus.iorq2_n),  32'(ei2));
                chk(nm, "drive_ff", 32'(bus.drive_ff), 32'(edf));
                chk(nm, "busy",     32'(bus.busy),     32'd1);
            end
            if (k == ACT_AT + 1) begin
                bus.porthit = 1'($urandom_range(0, 1));
                bus.iorqge1 = 1'($urandom_range(0, 1));
                bus.iorqge2 = 1'($urandom_range(0, 1));
            end
        end
        chk(nm, "owner_frozen", 32'(bus.owner), 32'(eo));
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        tick();
        tick();
        chk(nm, "iorq1_n_hold", 32'(bus.iorq1_n), 32'(ei1));
        tick();
        chk(nm, "done_iorq1_n",  32'(bus.iorq1_n),  32'd1);
        chk(nm, "done_iorq2_n",  32'(bus.iorq2_n),  32'd1);
        chk(nm, "done_drive_ff", 32'(bus.drive_ff), 32'd0);
        chk(nm, "done_owner",    32'(bus.owner),    32'd0);
        chk(nm, "done_busy",     32'(bus.busy),     32'd1);
        tick();
        chk(nm, "idle_busy", 32'(bus.busy), 32'd0);
        chk(nm, "rd_count",   32'(rd_seen), 32'(erd));
        chk(nm, "wr_count",   32'(wr_seen), 32'(ewr));
        chk(nm, "inta_count", 32'(ia_seen), 32'd0);
        if (erd + ewr > 0) begin
            chk(nm, "strobe_latency", 32'(stb_tick - t0), 32'(STB_AT));
        end
    endtask

    task automatic run_inta(input int hold, input string nm);
        bus.porthit = 1'b1;
        bus.iorqge1 = 1'b0;
        bus.iorqge2 = 1'b0;
        bus.rd_n    = 1'b0;
        bus.wr_n    = 1'b1;
        tick();
        clear_counts();
        bus.iorq_n = 1'b0;
        bus.m1_n   = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            tick();
            if (k == SYNC + 1) begin
                chk(nm, "inta_stb", 32'(bus.inta_stb), 32'd1);
                chk(nm, "drive_ff", 32'(bus.drive_ff), 32'd1);
                chk(nm, "iorq1_n",  32'(bus.iorq1_n),  32'd1);
                chk(nm, "iorq2_n",  32'(bus.iorq2_n),  32'd1);
                chk(nm, "busy",     32'(bus.busy),     32'd1);
            end
            if (k == SYNC + 2) begin
                chk(nm, "inta_stb_end", 32'(bus.inta_stb), 32'd0);
                chk(nm, "drive_ff_held", 32'(bus.drive_ff), 32'd1);
            end
        end
        bus.iorq_n = 1'b1;
        bus.m1_n   = 1'b1;
        bus.rd_n   = 1'b1;
        tick();
        tick();
        tick();
        chk(nm, "done_drive_ff", 32'(bus.drive_ff), 32'd0);
        chk(nm, "done_busy",     32'(bus.busy),     32'd1);
        tick();
        chk(nm, "idle_busy",  32'(bus.busy), 32'd0);
        chk(nm, "inta_count", 32'(ia_seen),  32'd1);
        chk(nm, "io_count",   32'(rd_seen + wr_seen), 32'd0);
    endtask

    // IORQ pulse no longer than the settle window must fire nothing
    task automatic run_abort(input int pulse, input string nm);
        bus.porthit = 1'b1;
        bus.iorqge1 = 1'b0;
        bus.iorqge2 = 1'b0;
        bus.rd_n    = 1'b0;
        bus.wr_n    = 1'b1;
        bus.m1_n    = 1'b1;
        tick();
        clear_counts();
        bus.iorq_n = 1'b0;
        repeat (pulse) tick();
        bus.iorq_n = 1'b1;
        bus.rd_n   = 1'b1;
        repeat (8) tick();
        chk(nm, "strobes", 32'(rd_seen + wr_seen + ia_seen), 32'd0);
        chk_idle_outputs(nm);
    endtask

    task automatic run_reset_mid(input string nm);
        int busy_seen;
        bus.porthit = 1'b0;
        bus.iorqge1 = 1'b1;
        bus.iorqge2 = 1'b0;
        bus.rd_n    = 1'b1;
        bus.wr_n    = 1'b0;
        bus.m1_n    = 1'b1;
        tick();
        bus.iorq_n = 1'b0;
        repeat (ACT_AT) tick();
        chk(nm, "pre_owner",   32'(bus.owner),   32'd1);
        chk(nm, "pre_iorq1_n", 32'(bus.iorq1_n), 32'd0);
        rst_n = 1'b0;
        tick();
        chk_idle_outputs({nm, "_rst"});
        rst_n = 1'b1;
        clear_counts();
        busy_seen = 0;
        repeat (12) begin
            tick();
            if (bus.busy !== 1'b0) busy_seen++;
        end
        chk(nm, "busy_while_low", 32'(busy_seen), 32'd0);
        chk(nm, "strobes_while_low", 32'(rd_seen + wr_seen + ia_seen), 32'd0);
        bus.iorq_n = 1'b1;
        bus.wr_n   = 1'b1;
        repeat (4) tick();
        run_io(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12, {nm, "_next"});
    endtask

    initial begin
        logic p, g1, g2, rdl, wrl;
        int   op;
        bus.iorq_n  = 1'b1;
        bus.rd_n    = 1'b1;
        bus.wr_n    = 1'b1;
        bus.m1_n    = 1'b1;
        bus.porthit = 1'b0;
        bus.iorqge1 = 1'b0;
        bus.iorqge2 = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk_idle_outputs("reset");
        chk("reset", "strobes",
            32'(bus.io_rd_stb) + 32'(bus.io_wr_stb) + 32'(bus.inta_stb), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        run_io(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12, "int_rd");
        run_io(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12, "slot1_wr");
        run_io(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12, "free_rd");
        run_io(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12, "free_wr");
        run_io(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11, "int_wr");
        run_io(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 13, "int_both");
        run_io(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12, "slot2_rd");
        run_inta(8, "inta");
        for (int pl = 1; pl <= SETTLE; pl++) begin
            run_abort(pl, $sformatf("abort%0d", pl));
        end
        run_reset_mid("reset_mid");

        for (int i = 0; i < 10; i++) begin
            p   = 1'($urandom_range(0, 1));
            g1  = 1'($urandom_range(0, 1));
            g2  = 1'($urandom_range(0, 1));
            op  = int'($urandom_range(0, 3));
            rdl = (op == 0) || (op == 2);
            wrl = (op == 1) || (op == 2);
            run_io(p, g1, g2, rdl, wrl, int'($urandom_range(11, 16)),
                   $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
